// File: rtl/dcache_wb_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped write-back data cache.
// Used by dcache_wb and dcache_line_array.
package dcache_wb_pkg;

    localparam int ADDR_W       = 30;
    localparam int WORD_W       = 32;
    localparam int OFFSET_W     = 2;
    localparam int INDEX_W      = 3;
    localparam int TAG_W        = 25;
    localparam int LINE_W       = 128;
    localparam int BLOCK_ADDR_W = TAG_W + INDEX_W;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;

    // Word w of a line lives at bits [32w+31:32w].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFFSET_W-1:0] off);
        return line[{off, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for dcache_wb: valid/dirty bits (async reset) plus tag and data
// arrays (no reset), with a single-word store port and a whole-line fill port.
module dcache_line_array
    import dcache_wb_pkg::*;
#(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [INDEX_W-1:0]                  index,
    output logic                                rd_valid,
    output logic                                rd_dirty,
    output logic [TAG_W-1:0]                    rd_tag,
    output logic [WORDS_PER_BLOCK*WORD_W-1:0]   rd_line,
    input  logic                                word_we,
    input  logic [OFFSET_W-1:0]                 word_offset,
    input  logic [WORD_W-1:0]                   word_data,
    input  logic                                line_we,
    input  logic [TAG_W-1:0]                    line_tag,
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0]   line_data,
    input  logic                                clean_we
);

    localparam int LW = WORDS_PER_BLOCK * WORD_W;

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
    logic [LW-1:0]         data_q [NUM_BLOCKS];
    logic [LW-1:0]         data_d [NUM_BLOCKS];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = data_q[index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (word_we) begin
            data_d[index][{word_offset, 5'b00000} +: WORD_W] = word_data;
            dirty_d[index] = 1'b1;
        end
        if (clean_we) begin
            dirty_d[index] = 1'b0;
        end
        // A fill always leaves the line clean, whatever the store port did.
        if (line_we) begin
            data_d[index]  = line_data;
            tag_d[index]   = line_tag;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with hit/miss FSM.
// Define DCACHE_PERF_EN to build the perf_hit/perf_miss event counters.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [WORD_W-1:0]       proc_wdata,
    output logic                    proc_stall,
    output logic [WORD_W-1:0]       proc_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [BLOCK_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]       mem_wdata,
    input  logic [LINE_W-1:0]       mem_rdata,
    input  logic                    mem_ready,
    output logic [31:0]             perf_hit,
    output logic [31:0]             perf_miss
);

    logic [1:0]          state_q, state_d;
    logic [OFFSET_W-1:0] addr_off;
    logic [INDEX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]    addr_tag;
    logic                req;
    logic                hit;
    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                word_we, line_we, clean_we;

    assign addr_off = proc_addr[OFFSET_W-1:0];
    assign addr_idx = proc_addr[OFFSET_W +: INDEX_W];
    assign addr_tag = proc_addr[ADDR_W-1 -: TAG_W];
    assign req      = proc_read | proc_write;
    assign hit      = rd_valid && (rd_tag == addr_tag);

    // Don't-care unless a read hits in IDLE; always the addressed word.
    assign proc_rdata = line_word(rd_line, addr_off);

    dcache_line_array #(
        .NUM_BLOCKS      (NUM_BLOCKS),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_lines (
        .clk         (clk),
        .rst_n       (rst_n),
        .index       (addr_idx),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .word_we     (word_we),
        .word_offset (addr_off),
        .word_data   (proc_wdata),
        .line_we     (line_we),
        .line_tag    (addr_tag),
        .line_data   (mem_rdata),
        .clean_we    (clean_we)
    );

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        word_we    = 1'b0;
        line_we    = 1'b0;
        clean_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                proc_stall = req && !hit;
                if (req) begin
                    if (hit) begin
                        // A simultaneous read+write is a store.
                        word_we = proc_write;
                    end else if (rd_valid && rd_dirty) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, addr_idx};
                mem_wdata  = rd_line;
                if (mem_ready) begin
                    clean_we = 1'b1;
                    state_d  = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1 -: BLOCK_ADDR_W];
                if (mem_ready) begin
                    line_we = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_miss_q, perf_miss_d;
    logic        hit_evt, miss_evt;

    always_comb begin
        hit_evt     = (state_q == ST_IDLE) && req && hit;
        miss_evt    = (state_q == ST_IDLE) && (state_d != ST_IDLE);
        perf_hit_d  = perf_hit_q + {31'd0, hit_evt};
        perf_miss_d = perf_miss_q + {31'd0, miss_evt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`else
    assign perf_hit  = '0;
    assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb: miss/fill, store hit, dirty
// write-back, clean replacement and reset abort, with hand-computed expectations.
module tb_dcache_wb;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  perf_hit;
  logic [31:0]  perf_miss;

  int total;
  int bad;

  dcache_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DCACHE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change just after a falling edge, outputs are read #1 later
  task automatic drive_req(input logic rd, input logic wr, input logic [29:0] addr,
                           input logic [31:0] wdata);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    #1;
  endtask

  task automatic idle_req();
    proc_read  = 1'b0;
    proc_write = 1'b0;
    #1;
  endtask

  // Wait `wait_cycles` falling edges, then present a one-cycle mem_ready.
  task automatic mem_respond(input int wait_cycles, input logic [127:0] line);
    for (int i = 0; i < wait_cycles; i++) @(negedge clk);
    mem_rdata = line;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
  endtask

  logic [127:0] line_a;
  logic [127:0] line_b;
  logic [127:0] line_c;

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    line_a = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    line_b = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
    line_c = {32'h44444444, 32'h55555555, 32'h66666666, 32'hCAFEF00D};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", proc_stall, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_perf_hit", perf_hit, 0);
    check("rst_perf_miss", perf_miss, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // cold read miss at 0x10 -> allocate block 0x4, fill, then hit
    @(negedge clk);
    drive_req(1, 0, 30'h00000010, 0);
    check("miss_stall", proc_stall, 1);
    check("miss_idle_mem_read", mem_read, 0);
    @(negedge clk); #1;
    check("alloc_mem_read", mem_read, 1);
    check("alloc_mem_write", mem_write, 0);
    check("alloc_mem_addr", mem_addr, 28'h0000004);
    check("alloc_stall", proc_stall, 1);
    mem_respond(4, line_a);
    check("fill_stall", proc_stall, 0);
    check("fill_rdata", proc_rdata, 32'hDEADBEEF);

    // store hit then load hit on word 1
    @(negedge clk);
    drive_req(0, 1, 30'h00000011, 32'h12345678);
    check("wr_hit_stall", proc_stall, 0);
    check("wr_hit_mem_write", mem_write, 0);
    @(negedge clk);
    drive_req(1, 0, 30'h00000011, 0);
    check("rd_after_wr_stall", proc_stall, 0);
    check("rd_after_wr_data", proc_rdata, 32'h12345678);

    // conflicting read at 0x91 -> dirty victim written back, then allocate 0x24
    @(negedge clk);
    drive_req(1, 0, 30'h00000091, 0);
    check("conflict_stall", proc_stall, 1);
    @(negedge clk); #1;
    check("wb_mem_write", mem_write, 1);
    check("wb_mem_read", mem_read, 0);
    check("wb_mem_addr", mem_addr, 28'h0000004);
    check("wb_word1", mem_wdata[63:32], 32'h12345678);
    check("wb_word0", mem_wdata[31:0], 32'hDEADBEEF);
    mem_respond(0, '0);
    check("wb2alloc_mem_read", mem_read, 1);
    check("wb2alloc_mem_write", mem_write, 0);
    check("wb2alloc_mem_addr", mem_addr, 28'h0000024);
    mem_respond(2, line_b);
    check("fill2_stall", proc_stall, 0);
    check("fill2_rdata", proc_rdata, 32'hAAAA0001);
    @(negedge clk);
    idle_req();
    check("perf_hit_after_034", perf_hit, PERF_ON ? 32'd4 : 32'd0);
    check("perf_miss_after_034", perf_miss, PERF_ON ? 32'd2 : 32'd0);

    // clean conflicting line -> straight to allocate, no write-back
    @(negedge clk);
    drive_req(1, 0, 30'h00000010, 0);
    check("clean_miss_stall", proc_stall, 1);
    @(negedge clk); #1;
    check("clean_mem_write", mem_write, 0);
    check("clean_mem_read", mem_read, 1);
    check("clean_mem_addr", mem_addr, 28'h0000004);

    // reset mid-allocate aborts the fill at once
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_mem_read", mem_read, 0);
    check("abort_mem_write", mem_write, 0);
    check("abort_perf_miss", perf_miss, 0);
    idle_req();
    @(negedge clk);
    rst_n = 1'b1;

    // same address misses again after reset
    @(negedge clk);
    drive_req(1, 0, 30'h00000010, 0);
    check("remiss_stall", proc_stall, 1);
    @(negedge clk); #1;
    check("remiss_mem_read", mem_read, 1);
    check("remiss_mem_addr", mem_addr, 28'h0000004);
    mem_respond(1, line_c);
    check("refill_stall", proc_stall, 0);
    check("refill_rdata", proc_rdata, 32'hCAFEF00D);
    @(negedge clk);
    idle_req();
    check("perf_hit_end", perf_hit, PERF_ON ? 32'd1 : 32'd0);
    check("perf_miss_end", perf_miss, PERF_ON ? 32'd1 : 32'd0);
    check("idle_mem_addr", mem_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
